multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4, legal 1..4: instruction fetch beats (one byte per beat).
REQ-002 SHALL have parameter EN_BNE, default 1: when 1, BNE opcode is decoded; when 0, BNE is treated as illegal.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port op  in  6  opcode field of the instruction register.
REQ-006 SHALL have port zero  in  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  in  1  memory access completes this cycle; tie high for zero-wait memory.
REQ-008 SHALL have ports memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst  out  1 each: datapath strobes/selects.
REQ-009 SHALL have ports pcsource, alusrcb, aluop  out  2 each.
REQ-010 SHALL have port irwrite  out  WORD_BYTES  one-hot instruction-byte write enable.
REQ-011 SHALL have ports current_state  out  4  state code; fetch_idx  out  2  current fetch beat.
REQ-012 SHALL have port illegal_op  out  1  one-cycle pulse on undecodable opcode.

Function
REQ-013 SHALL encode states: FETCH=0001, DECODE=0101, MEMADR=0110, LBRD=0111, LBWR=1000, SBWR=1001, RTYPEEX=1010, RTYPEWR=1011, BEQEX=1100, JEX=1101, ADDIEX=1110, ADDIWR=1111, BNEEX=0010.
REQ-014 SHALL decode opcodes: LB=100000, SB=101000, RTYPE=000000, BEQ=100100, J=100010, ADDI=001000, BNE=100101.
REQ-015 FETCH SHALL drive memread=1, iord=0, alusrca=0, alusrcb=01, pcsource=00, aluop=00, and irwrite bit fetch_idx = mem_ready.
REQ-016 In FETCH, pcen SHALL equal mem_ready; with mem_ready=0, the state, fetch_idx, and all enables SHALL hold (no PC increment, no IR write).
REQ-017 fetch_idx SHALL increment on each FETCH beat completed with mem_ready=1; after beat WORD_BYTES-1 the state SHALL go to DECODE and fetch_idx SHALL return to 0.
REQ-018 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=00 for one cycle, then branch on op: LB/SB->MEMADR, RTYPE->RTYPEEX, BEQ->BEQEX, BNE->BNEEX (EN_BNE=1), J->JEX, ADDI->ADDIEX.
REQ-019 On any other op, DECODE SHALL go to FETCH and pulse illegal_op for exactly that DECODE cycle.
REQ-020 MEMADR SHALL drive alusrca=1, alusrcb=10, then go to LBRD (LB) or SBWR (SB).
REQ-021 LBRD SHALL drive memread=1, iord=1, hold until mem_ready=1, then go to LBWR.
REQ-022 LBWR SHALL drive regwrite=1, memtoreg=1, regdst=0, then go to FETCH.
REQ-023 SBWR SHALL drive memwrite=1, iord=1, hold until mem_ready=1, then go to FETCH.
REQ-024 RTYPEEX SHALL drive alusrca=1, alusrcb=00, aluop=10, then go to RTYPEWR; RTYPEWR SHALL drive regwrite=1, regdst=1, memtoreg=0, then go to FETCH.
REQ-025 BEQEX SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcen=zero; BNEEX SHALL drive the same with pcen=~zero; both then go to FETCH.
REQ-026 JEX SHALL drive pcsource=10, pcen=1, then go to FETCH.
REQ-027 ADDIEX SHALL drive alusrca=1, alusrcb=10, aluop=00, then go to ADDIWR; ADDIWR SHALL drive regwrite=1, regdst=0, memtoreg=0, then go to FETCH.
REQ-028 Every output not listed for a state SHALL be 0 in that state.
REQ-029 Outputs SHALL be combinational from current state, fetch_idx, op, zero, and mem_ready; state and fetch_idx SHALL be registered.

Reset
REQ-030 rst=0 SHALL immediately force state=FETCH and fetch_idx=0, regardless of clk, including mid-fetch or mid-instruction.
REQ-031 During reset, the output values SHALL equal the FETCH outputs with mem_ready gating, except pcen=0, irwrite=0, and illegal_op=0.
REQ-032 The first FETCH beat SHALL occur on the first rising clk with rst=1.

Verification
REQ-033 WORD_BYTES=4, mem_ready=1, op=LB -> irwrite 0001,0010,0100,1000 on four cycles; then DECODE, MEMADR, LBRD, LBWR, FETCH; 8 cycles per instruction.
REQ-034 mem_ready=0 for 3 cycles at fetch beat 1 -> state, fetch_idx=1, irwrite=0, pcen=0 held; beat advances on the cycle mem_ready=1.
REQ-035 op=BEQ with zero=1 -> pcen=1 in BEQEX; zero=0 -> pcen=0; EN_BNE=1, op=BNE, zero=0 -> pcen=1.
REQ-036 op=111111 -> illegal_op=1 for one cycle in DECODE, then next state is FETCH with fetch_idx=0.
REQ-037 WORD_BYTES=1, op=ADDI -> sequence FETCH, DECODE, ADDIEX, ADDIWR, FETCH; irwrite=1 only in FETCH.
REQ-038 rst=0 asserted mid-LBRD between clock edges -> state=0001 and fetch_idx=0 within the same cycle; no regwrite follows.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with byte-serial instruction fetch.
// Waits on mem_ready in fetch and data-memory states; flags undecodable opcodes in DECODE.
module multicycle_ctrl #(
   parameter int WORD_BYTES = 4,
   parameter bit EN_BNE     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            op,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  memread,
   output logic                  memwrite,
   output logic                  alusrca,
   output logic                  memtoreg,
   output logic                  iord,
   output logic                  pcen,
   output logic                  regwrite,
   output logic                  regdst,
   output logic [1:0]            pcsource,
   output logic [1:0]            alusrcb,
   output logic [1:0]            aluop,
   output logic [WORD_BYTES-1:0] irwrite,
   output logic [3:0]            current_state,
   output logic [1:0]            fetch_idx,
   output logic                  illegal_op
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'b0001,
      S_BNEEX   = 4'b0010,
      S_DECODE  = 4'b0101,
      S_MEMADR  = 4'b0110,
      S_LBRD    = 4'b0111,
      S_LBWR    = 4'b1000,
      S_SBWR    = 4'b1001,
      S_RTYPEEX = 4'b1010,
      S_RTYPEWR = 4'b1011,
      S_BEQEX   = 4'b1100,
      S_JEX     = 4'b1101,
      S_ADDIEX  = 4'b1110,
      S_ADDIWR  = 4'b1111
   } state_t;

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b100100;
   localparam logic [5:0] OP_J     = 6'b100010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BNE   = 6'b100101;

   localparam logic [1:0] LAST_BEAT = 2'(WORD_BYTES - 1);

   state_t     state, state_nx;
   logic [1:0] idx_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_FETCH;
         fetch_idx <= 2'd0;
      end else begin
         state     <= state_nx;
         fetch_idx <= idx_nx;
      end
   end

   assign current_state = state;

   always_comb begin
      state_nx   = state;
      idx_nx     = fetch_idx;
      memread    = 1'b0;
      memwrite   = 1'b0;
      alusrca    = 1'b0;
      memtoreg   = 1'b0;
      iord       = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      pcsource   = 2'b00;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      irwrite    = '0;
      illegal_op = 1'b0;
      unique case (state)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            // rst gates the write strobes so nothing lands while reset is held
            if (mem_ready && rst) begin
               pcen    = 1'b1;
               irwrite = WORD_BYTES'(1) << fetch_idx;
               if (fetch_idx == LAST_BEAT) begin
                  idx_nx   = 2'd0;
                  state_nx = S_DECODE;
               end else begin
                  idx_nx = fetch_idx + 2'd1;
               end
            end
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LB, OP_SB: state_nx = S_MEMADR;
               OP_RTYPE:     state_nx = S_RTYPEEX;
               OP_BEQ:       state_nx = S_BEQEX;
               OP_J:         state_nx = S_JEX;
               OP_ADDI:      state_nx = S_ADDIEX;
               OP_BNE: begin
                  if (EN_BNE) begin
                     state_nx = S_BNEEX;
                  end else begin
                     illegal_op = 1'b1;
                     state_nx   = S_FETCH;
                  end
               end
               default: begin
                  illegal_op = 1'b1;
                  state_nx   = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            state_nx = (op == OP_SB) ? S_SBWR : S_LBRD;
         end
         S_LBRD: begin
            memread = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_nx = S_LBWR;
         end
         S_LBWR: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            state_nx = S_FETCH;
         end
         S_SBWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
            if (mem_ready) state_nx = S_FETCH;
         end
         S_RTYPEEX: begin
            alusrca  = 1'b1;
            aluop    = 2'b10;
            state_nx = S_RTYPEWR;
         end
         S_RTYPEWR: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            state_nx = S_FETCH;
         end
         S_BEQEX, S_BNEEX: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            pcsource = 2'b01;
            pcen     = (state == S_BEQEX) ? zero : ~zero;
            state_nx = S_FETCH;
         end
         S_JEX: begin
            pcsource = 2'b10;
            pcen     = 1'b1;
            state_nx = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            state_nx = S_ADDIWR;
         end
         S_ADDIWR: begin
            regwrite = 1'b1;
            state_nx = S_FETCH;
         end
         default: begin
            state_nx = S_FETCH;
            idx_nx   = 2'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench: two controllers (4-beat fetch with BNE, 1-beat fetch without BNE)
// checked every cycle against a per-instruction step-list model.
module tb_multicycle_ctrl;

   localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, RT = 6'b000000, BEQ = 6'b100100;
   localparam logic [5:0] JJ = 6'b100010, ADDI = 6'b001000, BNE = 6'b100101;

   localparam int K_FETCH = 0, K_DECODE = 1, K_MEMADR = 2, K_LBRD = 3, K_LBWR = 4, K_SBWR = 5;
   localparam int K_RTEX = 6, K_RTWR = 7, K_BEQ = 8, K_BNE = 9, K_J = 10, K_ADDIEX = 11, K_ADDIWR = 12;

   typedef struct packed {
      logic memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
      logic [1:0] pcsource, alusrcb, aluop;
      logic [3:0] irwrite;
      logic [3:0] state;
      logic [1:0] fidx;
      logic       illegal;
   } exp_t;

   logic clk = 1'b0;
   logic rst, zero, mem_ready;
   logic [5:0] op0, op1;

   logic a_memread, a_memwrite, a_alusrca, a_memtoreg, a_iord, a_pcen, a_regwrite, a_regdst, a_illegal;
   logic [1:0] a_pcsource, a_alusrcb, a_aluop, a_fidx;
   logic [3:0] a_irwrite, a_state;
   logic b_memread, b_memwrite, b_alusrca, b_memtoreg, b_iord, b_pcen, b_regwrite, b_regdst, b_illegal;
   logic [1:0] b_pcsource, b_alusrcb, b_aluop, b_fidx;
   logic [0:0] b_irwrite;
   logic [3:0] b_state;

   always #5 clk = ~clk;

   multicycle_ctrl #(.WORD_BYTES(4), .EN_BNE(1'b1)) dut0 (
      .clk(clk), .rst(rst), .op(op0), .zero(zero), .mem_ready(mem_ready),
      .memread(a_memread), .memwrite(a_memwrite), .alusrca(a_alusrca), .memtoreg(a_memtoreg),
      .iord(a_iord), .pcen(a_pcen), .regwrite(a_regwrite), .regdst(a_regdst),
      .pcsource(a_pcsource), .alusrcb(a_alusrcb), .aluop(a_aluop), .irwrite(a_irwrite),
      .current_state(a_state), .fetch_idx(a_fidx), .illegal_op(a_illegal));

   multicycle_ctrl #(.WORD_BYTES(1), .EN_BNE(1'b0)) dut1 (
      .clk(clk), .rst(rst), .op(op1), .zero(zero), .mem_ready(mem_ready),
      .memread(b_memread), .memwrite(b_memwrite), .alusrca(b_alusrca), .memtoreg(b_memtoreg),
      .iord(b_iord), .pcen(b_pcen), .regwrite(b_regwrite), .regdst(b_regdst),
      .pcsource(b_pcsource), .alusrcb(b_alusrcb), .aluop(b_aluop), .irwrite(b_irwrite),
      .current_state(b_state), .fetch_idx(b_fidx), .illegal_op(b_illegal));

   // Model: each instruction is a list of steps (fetch beats, decode, then opcode-specific steps)
   int pk[2][16];
   int pb[2][16];
   int plen[2], ppos[2];
   int wbv[2] = '{4, 1};
   bit env[2] = '{1'b1, 1'b0};
   logic [5:0] nop[2];

   exp_t q0[$], q1[$];
   int n_tests = 0, n_fail = 0;
   bit mid_done = 0;

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 8))
         0: return LB;
         1: return SB;
         2: return RT;
         3: return BEQ;
         4: return BNE;
         5: return JJ;
         6: return ADDI;
         7: return 6'b111111;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic bit legal(logic [5:0] o, bit en_bne);
      if (o == LB || o == SB || o == RT || o == BEQ || o == JJ || o == ADDI) return 1'b1;
      if (o == BNE) return en_bne;
      return 1'b0;
   endfunction

   task automatic push_step(int i, int k, int b);
      pk[i][plen[i]] = k;
      pb[i][plen[i]] = b;
      plen[i]++;
   endtask

   task automatic refill(int i);
      plen[i] = 0;
      ppos[i] = 0;
      for (int b = 0; b < wbv[i]; b++) push_step(i, K_FETCH, b);
      push_step(i, K_DECODE, 0);
      nop[i] = pick_op();
   endtask

   task automatic append_exec(int i, logic [5:0] o);
      if (o == LB) begin push_step(i, K_MEMADR, 0); push_step(i, K_LBRD, 0); push_step(i, K_LBWR, 0); end
      else if (o == SB) begin push_step(i, K_MEMADR, 0); push_step(i, K_SBWR, 0); end
      else if (o == RT) begin push_step(i, K_RTEX, 0); push_step(i, K_RTWR, 0); end
      else if (o == BEQ) push_step(i, K_BEQ, 0);
      else if (o == BNE && env[i]) push_step(i, K_BNE, 0);
      else if (o == JJ) push_step(i, K_J, 0);
      else if (o == ADDI) begin push_step(i, K_ADDIEX, 0); push_step(i, K_ADDIWR, 0); end
   endtask

   task automatic advance(int i, logic [5:0] o, logic mr);
      int k;
      k = pk[i][ppos[i]];
      if ((k == K_FETCH || k == K_LBRD || k == K_SBWR) && !mr) return;
      if (k == K_DECODE) append_exec(i, o);
      ppos[i]++;
      if (ppos[i] == plen[i]) refill(i);
   endtask

   function automatic exp_t model_out(int k, int beat, logic [5:0] o, logic z, logic mr, logic rs, bit en_bne);
      exp_t e;
      e = '0;
      case (k)
         K_FETCH: begin
            e.memread = 1; e.alusrcb = 2'b01; e.state = 4'b0001; e.fidx = 2'(beat);
            e.pcen = mr & rs;
            e.irwrite = (mr & rs) ? 4'(1 << beat) : 4'b0;
         end
         K_DECODE: begin e.alusrcb = 2'b11; e.state = 4'b0101; e.illegal = !legal(o, en_bne); end
         K_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; e.state = 4'b0110; end
         K_LBRD:   begin e.memread = 1; e.iord = 1; e.state = 4'b0111; end
         K_LBWR:   begin e.regwrite = 1; e.memtoreg = 1; e.state = 4'b1000; end
         K_SBWR:   begin e.memwrite = 1; e.iord = 1; e.state = 4'b1001; end
         K_RTEX:   begin e.alusrca = 1; e.aluop = 2'b10; e.state = 4'b1010; end
         K_RTWR:   begin e.regwrite = 1; e.regdst = 1; e.state = 4'b1011; end
         K_BEQ:    begin e.alusrca = 1; e.aluop = 2'b01; e.pcsource = 2'b01; e.pcen = z; e.state = 4'b1100; end
         K_BNE:    begin e.alusrca = 1; e.aluop = 2'b01; e.pcsource = 2'b01; e.pcen = ~z; e.state = 4'b0010; end
         K_J:      begin e.pcsource = 2'b10; e.pcen = 1; e.state = 4'b1101; end
         K_ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; e.state = 4'b1110; end
         K_ADDIWR: begin e.regwrite = 1; e.state = 4'b1111; end
         default: e = '1;
      endcase
      return e;
   endfunction

   // Stimulus: advance the model on each edge, drive new inputs 1ns later, queue expectations
   initial begin
      bit do_rst;
      rst = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      refill(0); refill(1);
      op0 = nop[0]; op1 = nop[1];
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         if (rst) begin
            advance(0, op0, mem_ready);
            advance(1, op1, mem_ready);
         end else begin
            refill(0); refill(1);
         end
         #1;
         do_rst = 1'b0;
         if (c < 3) do_rst = 1'b1;
         else if (c > 40 && pk[0][ppos[0]] == K_LBRD && (!mid_done || $urandom_range(0, 7) == 0)) begin
            do_rst = 1'b1;
            mid_done = 1'b1;
         end else if ($urandom_range(0, 299) == 0) do_rst = 1'b1;
         rst = !do_rst;
         mem_ready = ($urandom_range(0, 3) != 0);
         zero = 1'($urandom_range(0, 1));
         if (do_rst) begin refill(0); refill(1); end
         op0 = nop[0];
         op1 = nop[1];
         q0.push_back(model_out(pk[0][ppos[0]], pb[0][ppos[0]], op0, zero, mem_ready, rst, env[0]));
         q1.push_back(model_out(pk[1][ppos[1]], pb[1][ppos[1]], op1, zero, mem_ready, rst, env[1]));
      end
      @(negedge clk);
      #2;
      n_tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
      end
      if (!mid_done) begin
         n_fail++;
         $display("FAIL coverage: mid-LBRD reset got 0, expected 1");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Monitor: sample both controllers mid-cycle and compare against queued expectations
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            a = {a_memread, a_memwrite, a_alusrca, a_memtoreg, a_iord, a_pcen, a_regwrite, a_regdst,
                 a_pcsource, a_alusrcb, a_aluop, a_irwrite, a_state, a_fidx, a_illegal};
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL dut0_wb4 t=%0t: got %h expected %h (state %b/%b)", $time, a, e, a.state, e.state);
            end
         end
         if (q1.size() != 0) begin
            e = q1.pop_front();
            a = {b_memread, b_memwrite, b_alusrca, b_memtoreg, b_iord, b_pcen, b_regwrite, b_regdst,
                 b_pcsource, b_alusrcb, b_aluop, {3'b000, b_irwrite}, b_state, b_fidx, b_illegal};
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL dut1_wb1 t=%0t: got %h expected %h (state %b/%b)", $time, a, e, a.state, e.state);
            end
         end
      end
   end

endmodule
